estagio_busca: RTL and testbench

Instruction-fetch stage of the MIPS32 pipeline. Holds the PC, drives the instruction-memory request handshake, and registers each fetched word into the IF/ID pipeline register. The IF/ID register's low half feeds the 16-bit input of the sign-extension stage. Taken-branch targets are computed from the sign-extended immediate that comes back from decode/execute.

---
 rtl/estagio_busca.sv | 131 +++++++++++++
 tb/tb_estagio_busca.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/estagio_busca.sv
// MIPS32 instruction-fetch stage: PC, imem handshake, one-entry stall buffer, IF/ID register.
// Optional FETCH_PERF_COUNTER_EN adds perf_fetched, a count of instructions delivered to IF/ID.
module estagio_busca #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_pc4,
    input  logic [31:0] branch_imm,
    input  logic        jump_taken,
    input  logic [25:0] jump_index,
    input  logic [31:0] jump_pc4,
    output logic [31:0] instr,
    output logic [15:0] imm,
    output logic [31:0] pc4,
    output logic        valid
`ifdef FETCH_PERF_COUNTER_EN
    ,
    output logic [31:0] perf_fetched
`endif
);
    typedef enum logic {FETCH, HELD} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [31:0] r_pc4, w_pc4_nxt;
    logic        r_valid, w_valid_nxt;
    logic [31:0] r_buf_instr, w_buf_instr_nxt;
    logic [31:0] r_buf_pc4, w_buf_pc4_nxt;
    logic        w_deliver;

    logic [31:0] w_pc_plus4, w_br_target, w_jp_target;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_br_target = branch_pc4 + {branch_imm[29:0], 2'b00};
    assign w_jp_target = {jump_pc4[31:28], jump_index, 2'b00};

    assign imem_req  = ~reset & (r_state == FETCH);
    assign imem_addr = r_pc;
    assign instr     = r_instr;
    assign imm       = r_instr[15:0];
    assign pc4       = r_pc4;
    assign valid     = r_valid;

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_instr_nxt     = r_instr;
        w_pc4_nxt       = r_pc4;
        w_valid_nxt     = r_valid;
        w_buf_instr_nxt = r_buf_instr;
        w_buf_pc4_nxt   = r_buf_pc4;
        w_deliver       = 1'b0;
        if (branch_taken) begin
            w_pc_nxt    = w_br_target;
            w_valid_nxt = 1'b0;
            w_state_nxt = FETCH;
        end else if (jump_taken) begin
            w_pc_nxt    = w_jp_target;
            w_valid_nxt = 1'b0;
            w_state_nxt = FETCH;
        end else if (r_state == FETCH) begin
            if (imem_ack) begin
                w_pc_nxt = w_pc_plus4;
                if (stall) begin
                    // Park the word; IF/ID stays frozen until stall drops.
                    w_buf_instr_nxt = imem_data;
                    w_buf_pc4_nxt   = w_pc_plus4;
                    w_state_nxt     = HELD;
                    if (flush) w_valid_nxt = 1'b0;
                end else begin
                    w_instr_nxt = imem_data;
                    w_pc4_nxt   = w_pc_plus4;
                    w_valid_nxt = 1'b1;
                    w_deliver   = 1'b1;
                end
            end else if (flush || !stall) begin
                w_valid_nxt = 1'b0;
            end
        end else begin
            // A flush while holding drops the parked word; its PC is not refetched.
            if (flush) begin
                w_valid_nxt = 1'b0;
                w_state_nxt = FETCH;
            end else if (!stall) begin
                w_instr_nxt = r_buf_instr;
                w_pc4_nxt   = r_buf_pc4;
                w_valid_nxt = 1'b1;
                w_deliver   = 1'b1;
                w_state_nxt = FETCH;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= FETCH;
            r_pc        <= RESET_PC;
            r_instr     <= 32'd0;
            r_pc4       <= 32'd0;
            r_valid     <= 1'b0;
            r_buf_instr <= 32'd0;
            r_buf_pc4   <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_instr     <= w_instr_nxt;
            r_pc4       <= w_pc4_nxt;
            r_valid     <= w_valid_nxt;
            r_buf_instr <= w_buf_instr_nxt;
            r_buf_pc4   <= w_buf_pc4_nxt;
        end
    end

`ifdef FETCH_PERF_COUNTER_EN
    logic [31:0] r_perf;
    always_ff @(posedge clock) begin
        if (reset)          r_perf <= 32'd0;
        else if (w_deliver) r_perf <= r_perf + 32'd1;
    end
    assign perf_fetched = r_perf;
`endif
endmodule

// File: tb/tb_estagio_busca.sv
// Scoreboard bench for estagio_busca: driver pushes predicted outputs, monitor pops and compares.
// Memory returns addr ^ 32'hA5A5_0000; directed test-plan scenarios followed by random traffic.
module tb_estagio_busca;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data;
    logic        stall = 1'b0, flush = 1'b0;
    logic        branch_taken = 1'b0, jump_taken = 1'b0;
    logic [31:0] branch_pc4 = 32'd0, branch_imm = 32'd0, jump_pc4 = 32'd0;
    logic [25:0] jump_index = 26'd0;
    logic [31:0] instr, pc4;
    logic [15:0] imm;
    logic        valid;
    logic [31:0] perf_fetched;

    always #5 clock = ~clock;
    assign imem_data = imem_addr ^ 32'hA5A5_0000;

    estagio_busca #(.RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_pc4(branch_pc4), .branch_imm(branch_imm),
        .jump_taken(jump_taken), .jump_index(jump_index), .jump_pc4(jump_pc4),
        .instr(instr), .imm(imm), .pc4(pc4), .valid(valid)
`ifdef FETCH_PERF_COUNTER_EN
        , .perf_fetched(perf_fetched)
`endif
    );
`ifndef FETCH_PERF_COUNTER_EN
    assign perf_fetched = 32'd0;
`endif

    typedef struct {
        logic        req;
        logic [31:0] addr, instr, pc4, perf;
        logic        valid;
    } exp_t;
    exp_t sb[$];

    int n_vec = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: program-order view of the fetch stage.
    logic [31:0] m_pc = 32'd0, m_instr = 32'd0, m_pc4 = 32'd0, m_perf = 32'd0;
    logic        m_valid = 1'b0;
    logic [63:0] m_parked[$];   // at most one fetched-but-not-delivered {word, pc+4}

    task automatic step(input bit rst, input bit ack, input bit stl, input bit fl,
                        input bit br, input logic [31:0] bpc4, input logic [31:0] bimm,
                        input bit jp, input logic [25:0] jidx, input logic [31:0] jpc4);
        exp_t e;
        @(negedge clock);
        reset = rst; imem_ack = ack; stall = stl; flush = fl;
        branch_taken = br; branch_pc4 = bpc4; branch_imm = bimm;
        jump_taken = jp; jump_index = jidx; jump_pc4 = jpc4;
        if (rst) begin
            m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0; m_perf = 32'd0;
            m_parked.delete();
        end else if (br || jp) begin
            m_pc = br ? bpc4 + bimm * 4 : {jpc4[31:28], jidx, 2'b00};
            m_valid = 1'b0;
            m_parked.delete();
        end else if (m_parked.size() != 0) begin
            if (fl) begin
                m_parked.delete();
                m_valid = 1'b0;
            end else if (!stl) begin
                {m_instr, m_pc4} = m_parked.pop_front();
                m_valid = 1'b1;
                m_perf++;
            end
        end else if (ack) begin
            if (stl) begin
                m_parked.push_back({m_pc ^ 32'hA5A5_0000, m_pc + 32'd4});
                if (fl) m_valid = 1'b0;
            end else begin
                m_instr = m_pc ^ 32'hA5A5_0000;
                m_pc4 = m_pc + 32'd4;
                m_valid = 1'b1;
                m_perf++;
            end
            m_pc = m_pc + 32'd4;
        end else if (fl || !stl) begin
            m_valid = 1'b0;
        end
        e.req = !rst && (m_parked.size() == 0);
        e.addr = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid; e.perf = m_perf;
        sb.push_back(e);
    endtask

    task automatic nrm(input bit ack, input bit stl, input bit fl);
        step(1'b0, ack, stl, fl, 1'b0, 32'd0, 32'd0, 1'b0, 26'd0, 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("imem_req", {31'd0, imem_req}, {31'd0, e.req});
                chk("imem_addr", imem_addr, e.addr);
                chk("valid", {31'd0, valid}, {31'd0, e.valid});
                if (e.valid) begin
                    chk("instr", instr, e.instr);
                    chk("imm", {16'd0, imm}, {16'd0, e.instr[15:0]});
                    chk("pc4", pc4, e.pc4);
                end
`ifdef FETCH_PERF_COUNTER_EN
                chk("perf_fetched", perf_fetched, e.perf);
`endif
            end
        end
    end

    initial begin : driver
        logic [31:0] r_imm;
        // Reset state, including an ack offered during reset.
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Zero-wait fetch, then a 3-cycle stall on the ack at PC 8, then release.
        nrm(1, 0, 0); nrm(1, 0, 0);
        nrm(1, 1, 0); nrm(1, 1, 0); nrm(1, 1, 0);
        nrm(1, 0, 0); nrm(1, 0, 0); nrm(1, 0, 0);
        // Backward branch with a simultaneous jump (branch wins).
        step(0, 1, 0, 0, 1, 32'h100, 32'hFFFF_FFFC, 1, 26'h3FF_FFFF, 32'hF000_0000);
        nrm(1, 0, 0); nrm(1, 0, 0);
        // Jump with the redirect-cycle ack dropped.
        step(0, 1, 0, 0, 0, 0, 0, 1, 26'h000_0040, 32'hA000_0004);
        nrm(1, 0, 0); nrm(0, 0, 0); nrm(1, 0, 0);
        // PC wrap from 32'hFFFF_FFFC to 0.
        step(0, 0, 0, 0, 0, 0, 0, 1, 26'h3FF_FFFF, 32'hF000_0000);
        nrm(1, 0, 0); nrm(1, 0, 0);
        // Flush cases: with ack, with ack+stall, while held, and with no ack.
        nrm(1, 0, 1); nrm(1, 1, 1); nrm(0, 1, 0); nrm(0, 0, 0); nrm(1, 0, 0);
        nrm(1, 1, 0); nrm(0, 1, 1); nrm(1, 0, 0); nrm(0, 0, 1); nrm(0, 1, 0);
        // Reset while held.
        nrm(1, 1, 0);
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        nrm(1, 0, 0); nrm(1, 0, 0);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            r_imm = {{16{$urandom_range(1, 0) == 1}}, 16'($urandom)};
            step($urandom_range(99, 0) == 0, $urandom_range(9, 0) < 7, $urandom_range(3, 0) == 0,
                 $urandom_range(11, 0) == 0, $urandom_range(19, 0) == 0, {$urandom} & 32'hFFFF_FFFC,
                 r_imm, $urandom_range(19, 0) == 0, 26'($urandom), $urandom);
        end
        nrm(1, 0, 0);
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clock);
        #2;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
